// File: rtl/trace_port_arbiter.sv
// Trace-port controller: timestamps events from four sources, queues them per source and
// arbitrates them onto one valid/ready port. Define TRACE_ARB_STRICT_PRIO_EN for fixed priority.
module trace_port_arbiter #(
    parameter int DW    = 32,
    parameter int TSW   = 28,
    parameter int DEPTH = 4
) (
    input  logic                CLKF,
    input  logic                MASRSTN,
    input  logic [4*DW-1:0]     tp_in,
    input  logic [3:0]          tpe_in,
    output logic [DW+TSW+3:0]   trace_out,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [3:0]          ovf,
    input  logic                ovf_clr,
    output logic [TSW-1:0]      ts_now
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DW + TSW;
    localparam int OW = DW + TSW + 4;

    logic [TSW-1:0] r_ts;
    logic [EW-1:0]  r_mem [4][DEPTH];
    logic [AW:0]    r_wptr [4];
    logic [AW:0]    r_rptr [4];
    logic [3:0]     r_ovf;
    logic [OW-1:0]  r_out;
    logic           r_valid;

    logic [3:0]     w_empty;
    logic [3:0]     w_full;
    logic [3:0]     w_push;
    logic [3:0]     w_pop;
    logic [3:0]     w_drop;
    logic           w_free;
    logic           w_gnt_vld;
    logic [1:0]     w_gnt;
    logic [EW-1:0]  w_head;

    assign ts_now      = r_ts;
    assign trace_out   = r_out;
    assign trace_valid = r_valid;
    assign ovf         = r_ovf;
    assign w_free      = !r_valid || trace_ready;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int i = 0; i < 4; i++) begin
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]) &&
                         (r_wptr[i][AW] != r_rptr[i][AW]);
        end
    end

`ifdef TRACE_ARB_STRICT_PRIO_EN
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (!w_empty[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = 2'(k);
            end
        end
    end
`else
    logic [1:0] r_rr;
    logic [1:0] w_idx;

    // Scan from the farthest offset down so the source closest to r_rr wins last.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        w_idx     = r_rr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr + 2'(k);
            if (!w_empty[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_rr <= 2'd0;
        end else if (w_free && w_gnt_vld) begin
            r_rr <= w_gnt + 2'd1;
        end
    end
`endif

    // A full FIFO still accepts a push when it is being popped in the same cycle.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int i = 0; i < 4; i++) begin
            w_pop[i]  = w_free && w_gnt_vld && (w_gnt == 2'(i));
            w_push[i] = tpe_in[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = tpe_in[i] && w_full[i] && !w_pop[i];
        end
    end

    assign w_head = r_mem[w_gnt][r_rptr[w_gnt][AW-1:0]];

    always_ff @(posedge CLKF) begin
        for (int i = 0; i < 4; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i][AW-1:0]] <= {tp_in[i*DW +: DW], r_ts};
            end
        end
    end

    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            for (int i = 0; i < 4; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + (AW+1)'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_ts  <= '0;
            r_ovf <= '0;
        end else begin
            r_ts  <= r_ts + TSW'(1);
            r_ovf <= (ovf_clr ? 4'b0000 : r_ovf) | w_drop;
        end
    end

    // Output register: reload whenever the sink has taken (or never had) the current packet.
    always_ff @(posedge CLKF or negedge MASRSTN) begin
        if (!MASRSTN) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (w_free) begin
            if (w_gnt_vld) begin
                r_valid <= 1'b1;
                r_out   <= {w_head, 4'(w_gnt) + 4'd1};
            end else begin
                r_valid <= 1'b0;
                r_out   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_trace_port_arbiter.sv
// Directed bench for trace_port_arbiter: single event, simultaneous events, backpressure,
// arbitration fairness, reset mid-operation and timestamp wrap (on a narrow-counter instance).
module tb_trace_port_arbiter;
    localparam int DW    = 32;
    localparam int TSW   = 28;
    localparam int DEPTH = 4;
    localparam int WTSW  = 4;

    logic              CLKF = 1'b0;
    logic              MASRSTN = 1'b0;
    logic [4*DW-1:0]   tp_in;
    logic [3:0]        tpe_in;
    logic [DW+TSW+3:0] trace_out;
    logic              trace_valid;
    logic              trace_ready;
    logic [3:0]        ovf;
    logic              ovf_clr;
    logic [TSW-1:0]    ts_now;

    logic [4*DW-1:0]    w_tp;
    logic [3:0]         w_tpe;
    logic [DW+WTSW+3:0] w_out;
    logic               w_valid;
    logic               w_ready;
    logic [3:0]         w_ovf;
    logic               w_ovf_clr;
    logic [WTSW-1:0]    w_ts;

    int n_tests = 0;
    int n_fail  = 0;

    trace_port_arbiter #(.DW(DW), .TSW(TSW), .DEPTH(DEPTH)) u_dut (
        .CLKF(CLKF), .MASRSTN(MASRSTN), .tp_in(tp_in), .tpe_in(tpe_in),
        .trace_out(trace_out), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .ovf(ovf), .ovf_clr(ovf_clr), .ts_now(ts_now)
    );

    trace_port_arbiter #(.DW(DW), .TSW(WTSW), .DEPTH(DEPTH)) u_dut_wrap (
        .CLKF(CLKF), .MASRSTN(MASRSTN), .tp_in(w_tp), .tpe_in(w_tpe),
        .trace_out(w_out), .trace_valid(w_valid), .trace_ready(w_ready),
        .ovf(w_ovf), .ovf_clr(w_ovf_clr), .ts_now(w_ts)
    );

    always #5 CLKF = ~CLKF;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [31:0] p, input logic [27:0] t,
                                       input logic [3:0] id);
        return {p, t, id};
    endfunction

    task automatic tick();
        @(posedge CLKF);
        #1;
    endtask

    task automatic wait_ts(input logic [27:0] t);
        int n;
        n = 0;
        while (ts_now !== t && n < 300) begin
            tick();
            n++;
        end
        chk("wait_ts", 64'(ts_now), 64'(t));
    endtask

    task automatic do_reset();
        @(negedge CLKF);
        MASRSTN = 1'b0;
        @(negedge CLKF);
        MASRSTN = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] t0;
        logic [31:0] p;
        logic [3:0]  id;
        int          n;

        tp_in = '0; tpe_in = '0; trace_ready = 1'b0; ovf_clr = 1'b0;
        w_tp = '0; w_tpe = '0; w_ready = 1'b1; w_ovf_clr = 1'b0;

        // Reset state
        tick();
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_out", 64'(trace_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ts", 64'(ts_now), 64'd0);
        @(negedge CLKF);
        MASRSTN = 1'b1;

        // Single FFT event at ts=10
        trace_ready = 1'b1;
        wait_ts(28'd10);
        tpe_in = 4'b0100;
        tp_in[2*DW +: DW] = 32'hDEAD_BEEF;
        tick();
        tpe_in = '0;
        chk("single_lat1_valid", 64'(trace_valid), 64'd0);
        tick();
        chk("single_ts", 64'(ts_now), 64'd12);
        chk("single_valid", 64'(trace_valid), 64'd1);
        chk("single_out", 64'(trace_out), pk(32'hDEADBEEF, 28'd10, 4'd3));
        tick();
        chk("single_after_valid", 64'(trace_valid), 64'd0);
        chk("single_after_out", 64'(trace_out), 64'd0);

        // Simultaneous events from all sources at ts=5 with rr=0
        do_reset();
        wait_ts(28'd5);
        tpe_in = 4'b1111;
        tp_in = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        tick();
        tpe_in = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("simul_valid", 64'(trace_valid), 64'd1);
            chk("simul_out", 64'(trace_out), pk(32'hA000_0000 + 32'(i), 28'd5, 4'(i + 1)));
            tick();
        end
        chk("simul_end_valid", 64'(trace_valid), 64'd0);

        // Backpressure on source 1: six strobes, one held, four queued, one dropped
        trace_ready = 1'b0;
        t0 = ts_now;
        for (int k = 0; k < 6; k++) begin
            tpe_in = 4'b0010;
            tp_in[1*DW +: DW] = 32'hB000_0000 + 32'(k);
            tick();
            if (k < 5) chk("bp_ovf_clear", 64'(ovf), 64'd0);
            else       chk("bp_ovf_set", 64'(ovf), 64'h2);
            if (k >= 1) chk("bp_hold", 64'(trace_out), pk(32'hB000_0000, t0, 4'd2));
        end
        tpe_in = '0;
        trace_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", 64'(trace_valid), 64'd1);
            chk("bp_drain_out", 64'(trace_out),
                pk(32'hB000_0000 + 32'(k), t0 + 28'(k), 4'd2));
            tick();
        end
        chk("bp_empty_valid", 64'(trace_valid), 64'd0);
        chk("bp_ovf_sticky", 64'(ovf), 64'h2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("bp_ovf_cleared", 64'(ovf), 64'd0);

        // Sources 0 and 2 strobing every cycle for 20 cycles
        do_reset();
        tick();
        t0 = ts_now;
        for (int s = 0; s < 22; s++) begin
            if (s >= 2) begin
                n = s - 2;
`ifdef TRACE_ARB_STRICT_PRIO_EN
                id = 4'd1;
                chk("fair_id", 64'(trace_out[3:0]), 64'(id));
                chk("fair_out", 64'(trace_out), pk(32'hC000_0000 + 32'(n), t0 + 28'(n), id));
`else
                id = (n % 2 == 0) ? 4'd1 : 4'd3;
                p  = ((n % 2 == 0) ? 32'hC000_0000 : 32'hD000_0000) + 32'(n / 2);
                chk("fair_id", 64'(trace_out[3:0]), 64'(id));
                if (n < 10) chk("fair_out", 64'(trace_out), pk(p, t0 + 28'(n / 2), id));
`endif
            end
            if (s < 20) begin
                tpe_in = 4'b0101;
                tp_in[0 +: DW]    = 32'hC000_0000 + 32'(s);
                tp_in[2*DW +: DW] = 32'hD000_0000 + 32'(s);
            end else begin
                tpe_in = '0;
            end
            tick();
        end
        tpe_in = '0;
        n = 0;
        while (trace_valid && n < 30) begin
            tick();
            n++;
        end
        chk("fair_drained", 64'(trace_valid), 64'd0);
`ifdef TRACE_ARB_STRICT_PRIO_EN
        chk("fair_ovf", 64'(ovf), 64'h4);
`else
        chk("fair_ovf", 64'(ovf), 64'h5);
`endif

        // Reset asserted mid-operation with packets queued and ovf set
        trace_ready = 1'b0;
        tpe_in = 4'b1111;
        tick();
        tpe_in = '0;
        tick();
        chk("mid_pre_valid", 64'(trace_valid), 64'd1);
        MASRSTN = 1'b0;
        #2;
        chk("mid_async_valid", 64'(trace_valid), 64'd0);
        chk("mid_async_out", 64'(trace_out), 64'd0);
        chk("mid_async_ovf", 64'(ovf), 64'd0);
        chk("mid_async_ts", 64'(ts_now), 64'd0);
        tick();
        chk("mid_hold_valid", 64'(trace_valid), 64'd0);
        @(negedge CLKF);
        MASRSTN = 1'b1;
        #1;
        chk("mid_ts_restart", 64'(ts_now), 64'd0);
        trace_ready = 1'b1;
        tick();
        chk("mid_ts_first", 64'(ts_now), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("mid_no_stale", 64'(trace_valid), 64'd0);
            tick();
        end

        // Timestamp wrap on the narrow-counter instance
        n = 0;
        while (w_ts !== 4'hF && n < 40) begin
            tick();
            n++;
        end
        chk("wrap_wait", 64'(w_ts), 64'hF);
        w_tpe = 4'b1000;
        w_tp[3*DW +: DW] = 32'h1111_1111;
        tick();
        chk("wrap_ts_zero", 64'(w_ts), 64'd0);
        w_tp[3*DW +: DW] = 32'h2222_2222;
        tick();
        w_tpe = '0;
        chk("wrap_first_valid", 64'(w_valid), 64'd1);
        chk("wrap_first", 64'(w_out), 64'({32'h1111_1111, 4'hF, 4'd4}));
        tick();
        chk("wrap_second", 64'(w_out), 64'({32'h2222_2222, 4'h0, 4'd4}));
        tick();
        chk("wrap_end_valid", 64'(w_valid), 64'd0);
        chk("wrap_ovf", 64'(w_ovf), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
